// File: rtl/wcentroid_calc.sv
// wcentroid_calc: weighted centroid (sum W*X / sum W, sum W*Y / sum W) of an NPTS-point frame.
// Latency: READY pulses DW cycles after the last sample is accepted; minimum frame period NPTS+DW.
// Backpressure: IN_READY is low for the DW divide cycles; IN_VALID is ignored then, nothing is buffered.
// Optional build macro ROUND_NEAREST_EN: round-half-up results (default build truncates toward zero).
module wcentroid_calc #(
    parameter int DW   = 8,
    parameter int WW   = 4,
    parameter int NPTS = 6
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [DW-1:0] Xi,
    input  logic [DW-1:0] Yi,
    input  logic [WW-1:0] Wi,
    output logic          READY,
    output logic [DW-1:0] Xc,
    output logic [DW-1:0] Yc,
    output logic          ERR,
    output logic          BUSY
);
    localparam int CW  = $clog2(NPTS);
    localparam int SW  = WW + CW;
    localparam int AW  = DW + WW + CW;
    localparam int ITW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic {ACCUM = 1'b0, DIV = 1'b1} state_t;
    state_t state, state_nxt;

    // Lane 0 carries X, lane 1 carries Y; both share the weight sum as divisor.
    logic [CW-1:0]  cnt;
    logic [ITW-1:0] it;
    logic [SW-1:0]  asum;
    logic [AW-1:0]  acc   [2];
    logic [SW-1:0]  rem   [2];
    logic [DW-1:0]  sh    [2];
    logic [DW-2:0]  q     [2];

    logic [DW-1:0]  coord [2];
    logic [AW-1:0]  wprod [2];
    logic [AW-1:0]  dvd   [2];
    logic [SW:0]    trial [2];
    logic [SW-1:0]  nrem  [2];
    logic [DW-1:0]  nsh   [2];
    logic [DW-1:0]  nq    [2];
    logic           ge    [2];

    logic accept;
    logic last_beat;
    logic first_iter;
    logic last_iter;
    logic zero_sum;

    assign coord[0]   = Xi;
    assign coord[1]   = Yi;
    assign accept     = IN_VALID && (state == ACCUM);
    assign last_beat  = accept && (cnt == CW'(NPTS - 1));
    assign first_iter = (it == '0);
    assign last_iter  = (state == DIV) && (it == ITW'(DW - 1));
    assign zero_sum   = (asum == '0);

    // Per-lane weighted product and one restoring-division step; on the first step the
    // partial remainder is seeded from the upper SW bits of the dividend (always < divisor).
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            wprod[l] = {{(AW-WW){1'b0}}, Wi} * {{(AW-DW){1'b0}}, coord[l]};
`ifdef ROUND_NEAREST_EN
            dvd[l]   = acc[l] + {{(AW-SW+1){1'b0}}, asum[SW-1:1]};
`else
            dvd[l]   = acc[l];
`endif
            trial[l] = first_iter ? {dvd[l][AW-1:DW], dvd[l][DW-1]} : {rem[l], sh[l][DW-1]};
            nsh[l]   = first_iter ? {dvd[l][DW-2:0], 1'b0} : {sh[l][DW-2:0], 1'b0};
            ge[l]    = (trial[l] >= {1'b0, asum});
            nrem[l]  = ge[l] ? SW'(trial[l] - {1'b0, asum}) : trial[l][SW-1:0];
            nq[l]    = {q[l], ge[l]};
        end
    end

    // Next-state and handshake/status decode.
    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b0;
        BUSY      = 1'b0;
        case (state)
            ACCUM: begin
                IN_READY = 1'b1;
                if (last_beat) state_nxt = DIV;
            end
            DIV: begin
                BUSY = 1'b1;
                if (last_iter) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= ACCUM;
        else        state <= state_nxt;
    end

    // Accumulation, divider iteration and result/pulse registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt   <= '0;
            it    <= '0;
            asum  <= '0;
            READY <= 1'b0;
            Xc    <= '0;
            Yc    <= '0;
            ERR   <= 1'b0;
            for (int l = 0; l < 2; l++) begin
                acc[l] <= '0;
                rem[l] <= '0;
                sh[l]  <= '0;
                q[l]   <= '0;
            end
        end else begin
            READY <= 1'b0;
            if (accept) begin
                asum <= asum + {{CW{1'b0}}, Wi};
                cnt  <= last_beat ? '0 : cnt + 1'b1;
                it   <= '0;
                for (int l = 0; l < 2; l++) acc[l] <= acc[l] + wprod[l];
            end
            if (state == DIV) begin
                it <= it + 1'b1;
                for (int l = 0; l < 2; l++) begin
                    rem[l] <= nrem[l];
                    sh[l]  <= nsh[l];
                    q[l]   <= nq[l][DW-2:0];
                end
                if (last_iter) begin
                    // A zero weight sum makes every trial subtraction succeed; force a clean 0.
                    it    <= '0;
                    READY <= 1'b1;
                    ERR   <= zero_sum;
                    Xc    <= zero_sum ? '0 : nq[0];
                    Yc    <= zero_sum ? '0 : nq[1];
                    asum  <= '0;
                    for (int l = 0; l < 2; l++) acc[l] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_wcentroid_calc.sv
// Self-checking bench for wcentroid_calc: directed frames plus randomized frames
// compared against an arithmetic model of the weighted centroid.
module tb_wcentroid_calc;
    localparam int DW   = 8;
    localparam int WW   = 4;
    localparam int NPTS = 6;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [DW-1:0] Xi = '0;
    logic [DW-1:0] Yi = '0;
    logic [WW-1:0] Wi = '0;
    logic          READY;
    logic [DW-1:0] Xc;
    logic [DW-1:0] Yc;
    logic          ERR;
    logic          BUSY;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] bx [NPTS];
    logic [DW-1:0] by [NPTS];
    logic [WW-1:0] bw [NPTS];

    int            obs_lat;
    int            obs_low;
    logic [DW-1:0] obs_xc;
    logic [DW-1:0] obs_yc;
    logic          obs_err;
    bit            obs_got;
    bit            obs_busy_ok;
    bit            obs_hold_ok;
    bit            obs_pulse_ok;
    bit            obs_inrdy_ok;

    wcentroid_calc #(.DW(DW), .WW(WW), .NPTS(NPTS)) dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .Xi(Xi), .Yi(Yi), .Wi(Wi), .READY(READY), .Xc(Xc), .Yc(Yc),
        .ERR(ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Reference: centroid from plain integer sums.
    task automatic model(output logic [DW-1:0] ex, output logic [DW-1:0] ey, output logic ee);
        int sx, sy, sw;
        sx = 0; sy = 0; sw = 0;
        for (int i = 0; i < NPTS; i++) begin
            sx += int'(bw[i]) * int'(bx[i]);
            sy += int'(bw[i]) * int'(by[i]);
            sw += int'(bw[i]);
        end
        if (sw == 0) begin
            ex = '0; ey = '0; ee = 1'b1;
        end else begin
`ifdef ROUND_NEAREST_EN
            sx += sw / 2;
            sy += sw / 2;
`endif
            ex = DW'(sx / sw); ey = DW'(sy / sw); ee = 1'b0;
        end
    endtask

    task automatic fill_uniform(input logic [DW-1:0] x, input logic [DW-1:0] y);
        for (int i = 0; i < NPTS; i++) begin
            bx[i] = x; by[i] = y; bw[i] = 1;
        end
    endtask

    task automatic fill_random;
        for (int i = 0; i < NPTS; i++) begin
            bx[i] = DW'($urandom);
            by[i] = DW'($urandom);
            bw[i] = ($urandom_range(0, 3) == 0) ? '0 : WW'($urandom);
        end
    endtask

    // Drives one frame and records what the DUT did; the test tasks judge the observations.
    task automatic do_frame(input bit garbage, input bit gaps, input int abort_at);
        logic [DW-1:0] hx, hy;
        logic he;
        int n, guard;
        hx = Xc; hy = Yc; he = ERR;
        obs_got = 0; obs_lat = -1; obs_low = 0; obs_busy_ok = 1; obs_hold_ok = 1;
        obs_pulse_ok = 0; obs_inrdy_ok = 0;
        for (int i = 0; i < NPTS; i++) begin
            @(negedge CLK);
            if (gaps) begin
                IN_VALID = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge CLK);
            end
            IN_VALID = 1'b1; Xi = bx[i]; Yi = by[i]; Wi = bw[i];
            guard = 0;
            while (IN_READY !== 1'b1 && guard < 200) begin
                @(negedge CLK);
                guard++;
            end
            if (Xc !== hx || Yc !== hy || ERR !== he) obs_hold_ok = 0;
            @(posedge CLK);
        end
        n = 0;
        while (n < 4 * DW + 8) begin
            @(negedge CLK);
            n++;
            if (abort_at > 0 && n == abort_at) begin
                RESET = 1'b0;
                IN_VALID = 1'b0;
                return;
            end
            if (READY === 1'b1) begin
                obs_got = 1;
                break;
            end
            if (IN_READY === 1'b0) obs_low++;
            if (BUSY !== !IN_READY) obs_busy_ok = 0;
            if (Xc !== hx || Yc !== hy || ERR !== he) obs_hold_ok = 0;
            if (garbage) begin
                Xi = DW'($urandom); Yi = DW'($urandom); Wi = WW'($urandom);
            end else begin
                IN_VALID = 1'b0;
            end
        end
        IN_VALID = 1'b0;
        if (obs_got) begin
            obs_lat = n - 1;
            obs_xc = Xc; obs_yc = Yc; obs_err = ERR;
            obs_inrdy_ok = (IN_READY === 1'b1) && (BUSY === 1'b0);
            @(negedge CLK);
            obs_pulse_ok = (READY === 1'b0) && (Xc === obs_xc) && (Yc === obs_yc);
        end
    endtask

    task automatic test_reset;
        RESET = 1'b0; IN_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
        checks++; if (READY !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", READY); end
        checks++; if (Xc !== 8'h00 || Yc !== 8'h00) begin errors++; $display("FAIL reset_xy: got %h/%h want 00/00", Xc, Yc); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ERR); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        RESET = 1'b1;
        @(negedge CLK);
        checks++; if (IN_READY !== 1'b1 || READY !== 1'b0) begin errors++; $display("FAIL reset_release: in_ready %b ready %b want 1 0", IN_READY, READY); end
    endtask

    task automatic test_uniform;
        fill_uniform(8'h40, 8'h20);
        do_frame(0, 0, 0);
        checks++; if (!obs_got) begin errors++; $display("FAIL uniform_ready: no READY pulse seen"); end
        checks++; if (obs_lat !== DW) begin errors++; $display("FAIL uniform_latency: got %0d want %0d", obs_lat, DW); end
        checks++; if (obs_low !== DW) begin errors++; $display("FAIL uniform_in_ready_low: got %0d cycles want %0d", obs_low, DW); end
        checks++; if (obs_xc !== 8'h40 || obs_yc !== 8'h20) begin errors++; $display("FAIL uniform_xy: got %h/%h want 40/20", obs_xc, obs_yc); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL uniform_err: got %b want 0", obs_err); end
        checks++; if (!obs_pulse_ok) begin errors++; $display("FAIL uniform_pulse_width: READY not single-cycle or outputs moved"); end
        checks++; if (!obs_inrdy_ok) begin errors++; $display("FAIL uniform_ready_cycle: IN_READY/BUSY wrong in READY cycle"); end
        checks++; if (!obs_busy_ok) begin errors++; $display("FAIL uniform_busy: BUSY not the inverse of IN_READY during divide"); end
        checks++; if (!obs_hold_ok) begin errors++; $display("FAIL uniform_hold: outputs changed before READY"); end
    endtask

    task automatic test_weighted;
        bx[0] = 8'h10; by[0] = 8'h80; bw[0] = 3;
        bx[1] = 8'h40; by[1] = 8'h00; bw[1] = 1;
        for (int i = 2; i < NPTS; i++) begin
            bx[i] = DW'($urandom); by[i] = DW'($urandom); bw[i] = 0;
        end
        do_frame(0, 0, 0);
        checks++; if (!obs_got || obs_xc !== 8'h1C || obs_yc !== 8'h60 || obs_err !== 1'b0) begin
            errors++; $display("FAIL weighted: got %0d %h/%h err %b want 1C/60 err 0", obs_got, obs_xc, obs_yc, obs_err);
        end
    endtask

    task automatic test_rounding;
        logic [DW-1:0] want;
`ifdef ROUND_NEAREST_EN
        want = 8'h80;
`else
        want = 8'h7F;
`endif
        bx[0] = 8'hFF; by[0] = 8'hFF; bw[0] = 1;
        bx[1] = 8'h00; by[1] = 8'h00; bw[1] = 1;
        for (int i = 2; i < NPTS; i++) begin
            bx[i] = DW'($urandom); by[i] = DW'($urandom); bw[i] = 0;
        end
        do_frame(0, 0, 0);
        checks++; if (!obs_got || obs_xc !== want || obs_yc !== want) begin
            errors++; $display("FAIL rounding: got %h/%h want %h/%h", obs_xc, obs_yc, want, want);
        end
    endtask

    task automatic test_zero_weight;
        logic [DW-1:0] ex, ey;
        logic ee;
        for (int i = 0; i < NPTS; i++) begin
            bx[i] = DW'($urandom); by[i] = DW'($urandom); bw[i] = 0;
        end
        do_frame(0, 0, 0);
        checks++; if (obs_lat !== DW) begin errors++; $display("FAIL zero_latency: got %0d want %0d", obs_lat, DW); end
        checks++; if (obs_xc !== 8'h00 || obs_yc !== 8'h00 || obs_err !== 1'b1) begin
            errors++; $display("FAIL zero_weight: got %h/%h err %b want 00/00 err 1", obs_xc, obs_yc, obs_err);
        end
        fill_random;
        bw[0] = WW'($urandom_range(1, 15));
        model(ex, ey, ee);
        do_frame(0, 0, 0);
        checks++; if (obs_err !== 1'b0 || obs_xc !== ex || obs_yc !== ey) begin
            errors++; $display("FAIL zero_recover: got %h/%h err %b want %h/%h err 0", obs_xc, obs_yc, obs_err, ex, ey);
        end
    endtask

    task automatic test_backpressure;
        logic [DW-1:0] ex, ey;
        logic ee;
        fill_random;
        bw[0] = WW'($urandom_range(1, 15));
        model(ex, ey, ee);
        do_frame(1, 0, 0);
        checks++; if (obs_low !== DW) begin errors++; $display("FAIL bp_in_ready_low: got %0d cycles want %0d", obs_low, DW); end
        checks++; if (obs_xc !== ex || obs_yc !== ey || obs_err !== ee) begin
            errors++; $display("FAIL bp_first: got %h/%h err %b want %h/%h err %b", obs_xc, obs_yc, obs_err, ex, ey, ee);
        end
        fill_random;
        model(ex, ey, ee);
        do_frame(0, 0, 0);
        checks++; if (!obs_got || obs_xc !== ex || obs_yc !== ey || obs_err !== ee) begin
            errors++; $display("FAIL bp_next: got %h/%h err %b want %h/%h err %b", obs_xc, obs_yc, obs_err, ex, ey, ee);
        end
    endtask

    task automatic test_reset_mid_div;
        bit saw_ready;
        fill_uniform(8'h40, 8'h20);
        do_frame(0, 0, 0);
        fill_uniform(8'h33, 8'h99);
        do_frame(0, 0, 4);
        #1;
        checks++; if (Xc !== 8'h00 || Yc !== 8'h00 || ERR !== 1'b0) begin
            errors++; $display("FAIL abort_outputs: got %h/%h err %b want 00/00 err 0", Xc, Yc, ERR);
        end
        checks++; if (IN_READY !== 1'b1 || BUSY !== 1'b0) begin
            errors++; $display("FAIL abort_state: in_ready %b busy %b want 1 0", IN_READY, BUSY);
        end
        saw_ready = 0;
        repeat (DW + 2) begin
            @(negedge CLK);
            if (READY !== 1'b0) saw_ready = 1;
        end
        checks++; if (saw_ready) begin errors++; $display("FAIL abort_no_ready: READY seen 1 want 0"); end
        RESET = 1'b1;
        fill_uniform(8'h40, 8'h20);
        do_frame(0, 0, 0);
        checks++; if (!obs_got || obs_xc !== 8'h40 || obs_yc !== 8'h20 || obs_err !== 1'b0) begin
            errors++; $display("FAIL abort_recover: got %h/%h err %b want 40/20 err 0", obs_xc, obs_yc, obs_err);
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] ex, ey;
        logic ee;
        for (int f = 0; f < 20; f++) begin
            fill_random;
            model(ex, ey, ee);
            do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            checks++; if (obs_lat !== DW) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", f, obs_lat, DW); end
            checks++; if (obs_xc !== ex || obs_yc !== ey || obs_err !== ee) begin
                errors++; $display("FAIL rand_result[%0d]: got %h/%h err %b want %h/%h err %b", f, obs_xc, obs_yc, obs_err, ex, ey, ee);
            end
            checks++; if (!obs_hold_ok || !obs_pulse_ok) begin
                errors++; $display("FAIL rand_hold[%0d]: hold %0d pulse %0d want 1 1", f, obs_hold_ok, obs_pulse_ok);
            end
        end
    endtask

    initial begin
        test_reset;
        test_uniform;
        test_weighted;
        test_rounding;
        test_zero_weight;
        test_backpressure;
        test_reset_mid_div;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
